// File: rtl/soma_bcd_serial.sv
// Serial BCD adder/subtractor: one decimal digit per clock, least-significant
// digit first. Subtraction uses nines' complement of B plus an initial carry
// of 1, so the result is the ten's complement A-B+10^DIGITS.
//
// Handshake: a request is accepted on a rising edge where agora=1 and the
// FSM is idle (ocupado=0). The result (S, carry, erro) is valid in the single
// cycle where pronto=1 and is held until the next accepted request. Requests
// presented while ocupado=1 are dropped, never queued.
module soma_bcd_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  agora,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic [4*DIGITS-1:0]   S,
  output logic                  carry,
  output logic                  erro,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [1:0]            estado_dbg
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  estado_t               state_q, state_d;
  logic [4*DIGITS-1:0]   a_q, b_q;
  logic                  op_q;
  logic [IW-1:0]         idx_q;
  logic                  c_q;
  logic [4*DIGITS-1:0]   s_q;
  logic                  carry_q, erro_q;

  logic                  bad_in;
  logic                  last;
  logic [IW+1:0]         base;
  logic [3:0]            a_d, b_d, b_eff, dig;
  logic [4:0]            sum;
  logic                  cout;

  // Flag any non-BCD digit in the operands being presented for latching.
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  // One-digit decimal adder on the digit selected by idx_q.
  always_comb begin
    last  = (idx_q == IW'(DIGITS - 1));
    base  = {idx_q, 2'b00};
    a_d   = a_q[base +: 4];
    b_d   = b_q[base +: 4];
    b_eff = op_q ? (4'd9 - b_d) : b_d;
    sum   = {1'b0, a_d} + {1'b0, b_eff} + {4'b0000, c_q};
    cout  = (sum > 5'd9);
    // For sum in 10..19, adding 6 modulo 16 equals subtracting 10.
    dig   = cout ? (sum[3:0] + 4'd6) : sum[3:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (agora) state_d = bad_in ? FIM : CALC;
      CALC:    if (last)  state_d = FIM;
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // Operand latch, digit-serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (agora) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            idx_q   <= '0;
            c_q     <= op;
            s_q     <= '0;
            carry_q <= 1'b0;
            erro_q  <= bad_in;
          end
        end
        CALC: begin
          s_q[base +: 4] <= dig;
          c_q            <= cout;
          idx_q          <= idx_q + 1'b1;
          // Add reports overflow; subtract reports borrow (no final carry).
          if (last) carry_q <= op_q ? ~cout : cout;
        end
        default: ;
      endcase
    end
  end

  // Status and result outputs.
  always_comb begin
    S          = s_q;
    carry      = carry_q;
    erro       = erro_q;
    ocupado    = (state_q != OCIOSO);
    pronto     = (state_q == FIM);
    estado_dbg = state_q;
  end

endmodule

// File: tb/tb_soma_bcd_serial.sv
// Bench for soma_bcd_serial (DIGITS=4): decimal reference model, expected
// queue filled at request time and drained when pronto is observed.
module tb_soma_bcd_serial;

  localparam int D = 4;
  localparam int W = 4*D + 2;

  logic         clk, rst_n, agora, op;
  logic [4*D-1:0] a, b, s;
  logic         carry, erro, ocupado, pronto;
  logic [1:0]   estado_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  soma_bcd_serial #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .agora(agora), .op(op),
    .A(a), .B(b), .S(s), .carry(carry), .erro(erro),
    .ocupado(ocupado), .pronto(pronto), .estado_dbg(estado_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal reference: returns {erro, carry, S}.
  function automatic logic [W-1:0] model(input logic [4*D-1:0] x, y, input logic o);
    longint unsigned va = 0, vb = 0, p = 1, r = 0;
    logic bad = 1'b0;
    logic c = 1'b0;
    logic [4*D-1:0] res = '0;
    for (int i = D-1; i >= 0; i--) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
      va = va*10 + longint'(x[4*i +: 4]);
      vb = vb*10 + longint'(y[4*i +: 4]);
      p  = p*10;
    end
    if (bad) return {1'b1, 1'b0, {(4*D){1'b0}}};
    if (!o) begin
      r = va + vb;
      c = (r >= p);
      if (c) r = r - p;
    end else if (va < vb) begin
      r = va + p - vb;
      c = 1'b1;
    end else begin
      r = va - vb;
    end
    for (int i = 0; i < D; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {1'b0, c, res};
  endfunction

  function automatic logic [4*D-1:0] rand_bcd(input bit allow_bad);
    logic [4*D-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad) v[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // Driver: called at a falling edge; request is sampled at the next rising
  // edge, after which the inputs are scrambled (they must not matter).
  task automatic start_op(input logic [4*D-1:0] x, y, input logic o);
    exp_q.push_back(model(x, y, o));
    a = x; b = y; op = o; agora = 1'b1;
    @(posedge clk);
    #1;
    agora = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
  endtask

  // Waits (bounded) for pronto at falling edges; lat counts edges after the
  // request edge, offset adds edges already consumed by the caller.
  task automatic wait_result(input int offset, output int lat, output bit found);
    found = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pronto === 1'b1) begin
        lat = k + 1 + offset;
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({s, carry, erro, pronto, ocupado, estado_dbg} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got S=%h c=%b e=%b p=%b o=%b st=%0d want all 0",
               s, carry, erro, pronto, ocupado, estado_dbg);
    end
    agora = 1'b1; a = 16'h0001; b = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL agora_in_reset: got ocupado=%b want 0", ocupado);
    end
    agora = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [4*D-1:0] xa[3] = '{16'h0999, 16'h9999, 16'h4567};
    logic [4*D-1:0] xb[3] = '{16'h0001, 16'h0001, 16'h5433};
    logic [W-1:0] e;
    int lat; bit found;
    for (int i = 0; i < 3; i++) begin
      start_op(xa[i], xb[i], 1'b0);
      wait_result(0, lat, found);
      e = exp_q.pop_front();
      n_cmp++;
      if (!found || lat != D+1) begin
        n_err++;
        $display("FAIL add_latency[%0d]: got %0d (found=%b) want %0d", i, lat, found, D+1);
      end
      n_cmp++;
      if ({erro, carry, s} !== e) begin
        n_err++;
        $display("FAIL add_result[%0d]: got e=%b c=%b S=%h want e=%b c=%b S=%h",
                 i, erro, carry, s, e[W-1], e[W-2], e[4*D-1:0]);
      end
      @(negedge clk);
      n_cmp++;
      if ({pronto, ocupado, erro, carry, s} !== {2'b00, e}) begin
        n_err++;
        $display("FAIL add_hold[%0d]: got p=%b o=%b e=%b c=%b S=%h want p=0 o=0 e=%b c=%b S=%h",
                 i, pronto, ocupado, erro, carry, s, e[W-1], e[W-2], e[4*D-1:0]);
      end
    end
  endtask

  task automatic test_sub;
    logic [4*D-1:0] xa[3] = '{16'h0005, 16'h0012, 16'h1000};
    logic [4*D-1:0] xb[3] = '{16'h0007, 16'h0012, 16'h0001};
    logic [W-1:0] e;
    int lat; bit found;
    for (int i = 0; i < 3; i++) begin
      start_op(xa[i], xb[i], 1'b1);
      wait_result(0, lat, found);
      e = exp_q.pop_front();
      n_cmp++;
      if (!found || lat != D+1 || {erro, carry, s} !== e) begin
        n_err++;
        $display("FAIL sub_result[%0d]: got lat=%0d e=%b c=%b S=%h want lat=%0d e=%b c=%b S=%h",
                 i, lat, erro, carry, s, D+1, e[W-1], e[W-2], e[4*D-1:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_invalid;
    logic [4*D-1:0] xa[2] = '{16'h00A1, 16'h1234};
    logic [4*D-1:0] xb[2] = '{16'h0000, 16'h9F00};
    logic [W-1:0] e;
    int lat; bit found;
    for (int i = 0; i < 2; i++) begin
      start_op(xa[i], xb[i], 1'(i));
      wait_result(0, lat, found);
      e = exp_q.pop_front();
      n_cmp++;
      if (!found || lat != 1) begin
        n_err++;
        $display("FAIL invalid_latency[%0d]: got %0d (found=%b) want 1", i, lat, found);
      end
      n_cmp++;
      if ({erro, carry, s} !== e) begin
        n_err++;
        $display("FAIL invalid_result[%0d]: got e=%b c=%b S=%h want e=%b c=%b S=%h",
                 i, erro, carry, s, e[W-1], e[W-2], e[4*D-1:0]);
      end
      @(negedge clk);
    end
    // A following valid request must clear erro.
    start_op(16'h0003, 16'h0004, 1'b0);
    wait_result(0, lat, found);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || {erro, carry, s} !== e) begin
      n_err++;
      $display("FAIL erro_clear: got e=%b c=%b S=%h want e=%b c=%b S=%h",
               erro, carry, s, e[W-1], e[W-2], e[4*D-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_agora;
    logic [W-1:0] e;
    int lat; bit found;
    int extra = 0;
    start_op(16'h0999, 16'h0001, 1'b0);
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; op = 1'b1; agora = 1'b1;
    @(posedge clk);
    #1;
    agora = 1'b0;
    wait_result(1, lat, found);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != D+1 || {erro, carry, s} !== e) begin
      n_err++;
      $display("FAIL ignore_agora: got lat=%0d e=%b c=%b S=%h want lat=%0d e=%b c=%b S=%h",
               lat, erro, carry, s, D+1, e[W-1], e[W-2], e[4*D-1:0]);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pronto === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL ignore_extra_pronto: got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e;
    int lat; bit found;
    start_op(16'h0012, 16'h0012, 1'b1);
    wait_result(0, lat, found);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || {erro, carry, s} !== e) begin
      n_err++;
      $display("FAIL b2b_first: got e=%b c=%b S=%h want e=%b c=%b S=%h",
               erro, carry, s, e[W-1], e[W-2], e[4*D-1:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got ocupado=%b want 0", ocupado);
    end
    start_op(16'h0005, 16'h0007, 1'b1);
    wait_result(0, lat, found);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != D+1 || {erro, carry, s} !== e) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d e=%b c=%b S=%h want lat=%0d e=%b c=%b S=%h",
               lat, erro, carry, s, D+1, e[W-1], e[W-2], e[4*D-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [W-1:0] e;
    int lat; bit found;
    int extra = 0;
    start_op(16'h5555, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s, carry, erro, pronto, ocupado} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got S=%h c=%b e=%b p=%b o=%b want all 0",
               s, carry, erro, pronto, ocupado);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pronto === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL abort_pronto: got %0d pulses want 0", extra);
    end
    start_op(16'h0001, 16'h0002, 1'b0);
    wait_result(0, lat, found);
    e = exp_q.pop_front();
    n_cmp++;
    if (!found || lat != D+1 || {erro, carry, s} !== e) begin
      n_err++;
      $display("FAIL abort_fresh: got lat=%0d e=%b c=%b S=%h want lat=%0d e=%b c=%b S=%h",
               lat, erro, carry, s, D+1, e[W-1], e[W-2], e[4*D-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] e;
    int lat; bit found;
    bit bad;
    for (int i = 0; i < 12; i++) begin
      bad = ($urandom_range(0, 3) == 0);
      start_op(rand_bcd(bad), rand_bcd(1'b0), 1'($urandom_range(0, 1)));
      wait_result(0, lat, found);
      e = exp_q.pop_front();
      n_cmp++;
      if (!found || lat != (bad ? 1 : D+1) || {erro, carry, s} !== e) begin
        n_err++;
        $display("FAIL random[%0d]: got lat=%0d e=%b c=%b S=%h want lat=%0d e=%b c=%b S=%h",
                 i, lat, erro, carry, s, bad ? 1 : D+1, e[W-1], e[W-2], e[4*D-1:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b1; agora = 1'b0; op = 1'b0; a = '0; b = '0;
    #2;
    rst_n = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_invalid;
    test_ignore_agora;
    test_back_to_back;
    test_reset_abort;
    test_random;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/soma_bcd_serial.md
SOMA_BCD_SERIAL -- requirements
Module: soma_bcd_serial

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, meaning the number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port agora, input, 1 bit: start request, sampled on a rising clk edge.
REQ-005 SHALL provide port op, input, 1 bit: 0 = add A+B, 1 = subtract A-B; sampled together with agora.
REQ-006 SHALL provide port A, input, 4*DIGITS bits: BCD operand, least-significant digit in [3:0].
REQ-007 SHALL provide port B, input, 4*DIGITS bits: BCD operand, same packing as A.
REQ-008 SHALL provide port S, output, 4*DIGITS bits: BCD result, registered.
REQ-009 SHALL provide port carry, output, 1 bit: decimal carry-out (add) or borrow (subtract), registered.
REQ-010 SHALL provide port erro, output, 1 bit: set when a latched operand contains a non-BCD digit (>9), registered.
REQ-011 SHALL provide port ocupado, output, 1 bit: high whenever the FSM is not in OCIOSO.
REQ-012 SHALL provide port pronto, output, 1 bit: one-cycle pulse marking that S/carry/erro are valid.

Function
REQ-013 SHALL implement FSM states OCIOSO, CALC and FIM, with OCIOSO as the reset state.
REQ-014 SHALL, in OCIOSO with agora=1 at an edge, latch A, B and op, clear the digit index and the result register, and transition per REQ-015/REQ-016.
REQ-015 SHALL go OCIOSO->CALC when all 2*DIGITS latched digits are <=9.
REQ-016 SHALL go OCIOSO->FIM when any latched digit is >9, setting erro=1, S=0 and carry=0 at that edge.
REQ-017 SHALL, in CALC, process exactly one digit per clock, least-significant first, for DIGITS cycles, then go to FIM.
REQ-018 SHALL compute each digit as sum = a + b' + c, where b' = b for add and 9-b for subtract, and c is the running carry.
REQ-019 SHALL initialise the running carry to 0 for add and 1 for subtract.
REQ-020 SHALL produce a result digit of sum-10 with carry 1 when sum>9, and sum with carry 0 otherwise; sum never exceeds 19.
REQ-021 SHALL, at the end of an add, set carry to the final digit carry (1 = overflow beyond DIGITS digits; S holds the low DIGITS digits).
REQ-022 SHALL, at the end of a subtract, set carry to the inverse of the final digit carry (1 = A<B); S then holds the ten's complement, A-B+10^DIGITS.
REQ-023 SHALL drive pronto=1 for exactly the single cycle spent in FIM, then return to OCIOSO.
REQ-024 SHALL give a valid-operand latency of DIGITS+1 edges after the agora edge (5 for DIGITS=4) and an invalid-operand latency of 1 edge.
REQ-025 SHALL ignore agora while in CALC or FIM; op, A and B changes during a calculation SHALL have no effect.
REQ-026 SHALL accept agora=1 in the OCIOSO cycle immediately following FIM, so back-to-back operations are allowed.
REQ-027 SHALL hold S, carry and erro from FIM until the next accepted agora, which clears erro and S.
REQ-028 SHALL keep intermediate S digits unspecified while ocupado=1; the bench checks S only when pronto=1.

Reset
REQ-029 SHALL, on rst_n=0, immediately set S=0, carry=0, erro=0, pronto=0, ocupado=0 and the FSM to OCIOSO, independent of clk.
REQ-030 SHALL abort any calculation in progress when reset is asserted, with no pronto pulse for the aborted operation.
REQ-031 SHALL accept no agora while rst_n=0; the first sample SHALL be at the first rising edge with rst_n=1.

Verification (DIGITS=4)
REQ-032 SHALL cover: add A=0999, B=0001 -> pronto 5 edges after agora, S=1000, carry=0, erro=0.
REQ-033 SHALL cover: add A=9999, B=0001 -> S=0000, carry=1.
REQ-034 SHALL cover: subtract A=0005, B=0007 -> S=9998, carry=1; subtract A=0012, B=0012 -> S=0000, carry=0.
REQ-035 SHALL cover: A=00A1 (digit 0xA), add -> pronto 1 edge after agora, erro=1, S=0000, carry=0.
REQ-036 SHALL cover: agora pulsed again with different operands during CALC -> ignored, and the original result is delivered unchanged.
REQ-037 SHALL cover: rst_n pulsed low at the third CALC cycle -> outputs 0 at once, no pronto, then a fresh add 0001+0002 -> S=0003.
